uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 104 (12 MHz / 115200 baud), meaning clk cycles per UART bit; legal range 8..65535.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port rx  input  1  serial line from the FTDI tx pin; asynchronous to clk; idles high.
REQ-005 SHALL have port rx_data  output  8  last received byte.
REQ-006 SHALL have port rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-007 SHALL have port rx_ready  input  1  consumer accepts rx_data when rx_valid && rx_ready.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse when the stop bit samples low.
REQ-009 SHALL have port overrun  output  1  one-cycle pulse when a good byte is dropped because the holding register is full.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer (reset value 1); all decoding SHALL use the synchronized signal rx_s.
REQ-011 SHALL support 8N1 framing only: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity.
REQ-012 SHALL implement states IDLE, START, DATA, STOP; a bit counter (0..CLKS_PER_BIT-1) SHALL clear on every state entry and every data-bit advance.
REQ-013 IDLE: when rx_s is 0, SHALL go to START next cycle.
REQ-014 START: at count == (CLKS_PER_BIT-1)/2 (integer division), SHALL sample rx_s; if 1 (glitch), SHALL return to IDLE with no output; if 0, SHALL go to DATA.
REQ-015 DATA: at each count == CLKS_PER_BIT-1, SHALL shift rx_s into the shift register (bit index 0 first); after the 8th sample it SHALL go to STOP.
REQ-016 STOP: at count == CLKS_PER_BIT-1, SHALL sample rx_s and return to IDLE the next cycle, so back-to-back frames are received without gaps.
REQ-017 Stop sample 0: SHALL pulse frame_err for exactly 1 cycle, discard the byte, and leave rx_data and rx_valid unchanged.
REQ-018 Stop sample 1 with rx_valid == 0, or with rx_valid && rx_ready in the same cycle: SHALL load rx_data and assert rx_valid on the next edge.
REQ-019 Stop sample 1 with rx_valid && !rx_ready: SHALL pulse overrun for 1 cycle, keep the old rx_data, and drop the new byte.
REQ-020 rx_valid SHALL stay high, and rx_data SHALL stay stable, until a cycle with rx_ready == 1; rx_valid SHALL clear after that cycle unless REQ-018 reloads in the same cycle.
REQ-021 rx_ready while rx_valid == 0 SHALL have no effect.
REQ-022 No combinational path SHALL exist from rx or rx_ready to any output; all outputs SHALL be registered.

Reset
REQ-023 Reset asserted SHALL immediately force state IDLE, counters 0, shift register 0, synchronizer flops 1, rx_data 0x00, rx_valid 0, frame_err 0, overrun 0.
REQ-024 Reset mid-frame SHALL abandon the frame with no output; after release, the block SHALL wait for a fresh 1->0 transition on rx_s. A line still low at release SHALL be treated as a start bit (REQ-013).

Structure
REQ-025 A shared package uart_pkg SHALL hold the state encoding localparams and the default CLKS_PER_BIT, for reuse by a future uart_tx.
REQ-026 The synchronizer SHALL be a separate sub-module sync_2ff (1 bit, reset value parameter); everything else SHALL be flat in uart_rx.
REQ-027 Target size: 120-250 lines of RTL.

Verification (bench uses CLKS_PER_BIT = 16 and a behavioural serial driver)
REQ-028 Send 0x55 with rx_ready = 1 -> rx_valid high for exactly 1 cycle, rx_data = 0x55, no frame_err or overrun.
REQ-029 Send 0xA3, then 0x0F back-to-back with rx_ready held 0 -> overrun pulses once; rx_data stays 0xA3 until rx_ready = 1, then rx_valid clears.
REQ-030 Drive rx low for 5 cycles, then high -> no rx_valid, no frame_err; a following 0x81 frame is received correctly.
REQ-031 Send 0x3C with the stop bit driven low -> frame_err pulses 1 cycle, rx_valid stays 0; the next good frame 0xC3 is received.
REQ-032 Assert reset during data bit 4 of 0xFF -> all outputs 0 immediately; after release, a fresh 0x12 frame is received with rx_data = 0x12.
REQ-033 Send 256 random bytes at 1.5% baud offset (+ and -) with random rx_ready -> every accepted byte matches the sent sequence; every dropped byte is signalled by an overrun pulse.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg -- definitions shared by the UART blocks.
//   UART_CLKS_PER_BIT_DEFAULT : default clk cycles per bit (12 MHz / 115200 baud)
//   ST_*                      : receiver/transmitter FSM state encoding
package uart_pkg;

    localparam int unsigned UART_CLKS_PER_BIT_DEFAULT = 104;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff -- two-flop synchronizer for one asynchronous bit.
//   clk     : destination clock
//   reset   : asynchronous active-high reset, both flops load RESET_VAL
//   d_i     : asynchronous input
//   q_o     : synchronized output, two clk edges of latency
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx -- 8N1 UART receiver with a one-byte holding register.
//   clk        : system clock, all state on the rising edge
//   reset      : asynchronous active-high reset
//   rx         : serial input, asynchronous, idles high
//   rx_data    : last received byte
//   rx_valid   : rx_data holds an unconsumed byte
//   rx_ready   : consumer takes rx_data when rx_valid && rx_ready
//   frame_err  : one-cycle pulse when the stop bit samples low
//   overrun    : one-cycle pulse when a good byte is dropped (holding full)
//   dbg_state  : current FSM state (uart_pkg ST_* encoding), for observation
//
// Handshake: rx_valid/rx_data form a valid/ready source. Once rx_valid is
// high, rx_valid and rx_data hold until a cycle with rx_ready high; a byte
// transfers on every rising edge where rx_valid && rx_ready. rx_ready has
// no effect while rx_valid is low. All outputs come straight from flops.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic [1:0] dbg_state
);

    localparam logic [15:0] CNT_LAST = 16'(CLKS_PER_BIT - 1);
    // Start bit is checked half a bit in, so data samples land mid-bit.
    localparam logic [15:0] CNT_HALF = 16'((CLKS_PER_BIT - 1) / 2);

    logic        rx_s;

    logic [1:0]  state_q,     state_d;
    logic [15:0] cnt_q,       cnt_d;
    logic [2:0]  bit_idx_q,   bit_idx_d;
    logic [7:0]  shift_q,     shift_d;
    logic [7:0]  rx_data_q,   rx_data_d;
    logic        rx_valid_q,  rx_valid_d;
    logic        frame_err_q, frame_err_d;
    logic        overrun_q,   overrun_d;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (rx),
        .q_o   (rx_s)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        // Consumer handshake; a stop-bit load below may re-set it this cycle.
        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                if (!rx_s) begin
                    state_d = ST_START;
                end
            end

            ST_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    // High at mid start bit means a glitch: drop it silently.
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    // LSB arrives first, so shift in from the top.
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            ST_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    // Leave mid stop bit so a back-to-back start edge is seen.
                    state_d = ST_IDLE;
                    if (!rx_s) begin
                        frame_err_d = 1'b1;
                    end else if (!rx_valid_q || rx_ready) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- self-checking bench for uart_rx (CLKS_PER_BIT = 16).
// A serial driver sends frames and records every byte it sends in a
// queue; a per-cycle monitor checks the DUT against the receive contract
// (each good frame yields either a load or an overrun, in send order;
// each bad-stop frame yields one frame_err; held data stays stable).
module tb_uart_rx;
    import uart_pkg::*;

    timeunit 1ns;
    timeprecision 1ps;

    localparam int unsigned CPB      = 16;
    localparam real         BIT_NOM  = 160.0;   // 16 cycles x 10 ns
    localparam real         BIT_SLOW = 162.4;   // +1.5 %
    localparam real         BIT_FAST = 157.6;   // -1.5 %

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic [1:0] dbg_state;

    uart_rx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];          // good bytes sent, awaiting load or drop
    int         ferr_pending = 0;  // bad-stop frames awaiting frame_err
    int         n_load = 0;
    int         n_ovr = 0;
    int         n_ferr = 0;
    int         n_vcyc = 0;
    logic [7:0] last_data = 8'h00;
    int unsigned load_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- rx_ready driver ----------------
    logic ready_mode  = 1'b0;  // 0: forced value, 1: random
    logic ready_force = 1'b1;
    always @(posedge clk) begin
        #2;
        if (ready_mode) rx_ready = ($urandom_range(0, 249) == 0);
        else            rx_ready = ready_force;
    end

    // ---------------- serial driver ----------------
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input real bt);
        rx = 1'b0;
        #(bt);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(bt);
        end
        if (stop_bit) exp_q.push_back(b);
        else          ferr_pending++;
        rx = stop_bit;
        #(bt);
        rx = 1'b1;
    endtask

    // ---------------- per-cycle compare ----------------
    logic       p_valid = 1'b0;
    logic       p_ready = 1'b0;
    logic       p_ferr  = 1'b0;
    logic       p_ovr   = 1'b0;
    logic [7:0] p_data  = 8'h00;

    always @(negedge clk) begin
        logic       new_load;
        logic [7:0] e;
        if (reset) begin
            p_valid = 1'b0;
            p_ready = 1'b0;
            p_ferr  = 1'b0;
            p_ovr   = 1'b0;
            p_data  = 8'h00;
        end else begin
            new_load = rx_valid && (!p_valid || p_ready);
            if (p_valid && !p_ready) begin
                check("hold_valid", 32'(rx_valid), 32'd1);
                check("hold_data", 32'(rx_data), 32'(p_data));
            end
            if (frame_err) begin
                check("ferr_expected", 32'(ferr_pending > 0), 32'd1);
                check("ferr_width", 32'(p_ferr), 32'd0);
                if (ferr_pending > 0) ferr_pending--;
                n_ferr++;
            end
            if (overrun) begin
                check("ovr_when_full", 32'(p_valid && !p_ready), 32'd1);
                check("ovr_width", 32'(p_ovr), 32'd0);
                check("ovr_has_byte", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                n_ovr++;
            end
            if (new_load) begin
                check("load_has_byte", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("load_data", 32'(rx_data), 32'(e));
                end
                n_load++;
                last_data = rx_data;
                load_cyc  = cyc;
            end
            if (rx_valid) n_vcyc++;
            p_valid = rx_valid;
            p_ready = rx_ready;
            p_ferr  = frame_err;
            p_ovr   = overrun;
            p_data  = rx_data;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_drained(input string name);
        check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        check({name, "_ferr_drained"}, 32'(ferr_pending), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int         l0, o0, f0, v0;
        int unsigned s;
        logic [7:0] b;

        reset = 1'b1;
        rx = 1'b1;
        rx_ready = 1'b1;
        #1;
        check("rst_data", 32'(rx_data), 32'h00);
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        wait_cycles(5);
        reset = 1'b0;
        wait_cycles(10);

        // 0x55, consumer always ready. Load appears 155 edges after the
        // start edge is driven: 2 sync + 1 idle + 8 to mid start + 9*16.
        l0 = n_load; o0 = n_ovr; f0 = n_ferr; v0 = n_vcyc;
        @(posedge clk); #1;
        s = cyc;
        send_frame(8'h55, 1'b1, BIT_NOM);
        wait_cycles(20);
        check("t1_loads", 32'(n_load - l0), 32'd1);
        check("t1_data", 32'(last_data), 32'h55);
        check("t1_latency", load_cyc - s, 32'd155);
        check("t1_valid_cycles", 32'(n_vcyc - v0), 32'd1);
        check("t1_no_err", 32'((n_ovr - o0) + (n_ferr - f0)), 32'd0);

        // 0xA3 then 0x0F back-to-back, consumer stalled.
        ready_force = 1'b0;
        l0 = n_load; o0 = n_ovr;
        send_frame(8'hA3, 1'b1, BIT_NOM);
        send_frame(8'h0F, 1'b1, BIT_NOM);
        wait_cycles(20);
        check("t2_overrun", 32'(n_ovr - o0), 32'd1);
        check("t2_loads", 32'(n_load - l0), 32'd1);
        check("t2_valid_held", 32'(rx_valid), 32'd1);
        check("t2_data_held", 32'(rx_data), 32'hA3);
        ready_force = 1'b1;
        wait_cycles(3);
        ready_force = 1'b0;
        wait_cycles(3);
        check("t2_valid_cleared", 32'(rx_valid), 32'd0);
        ready_force = 1'b1;

        // Start-bit glitch of 5 cycles, then 0x81.
        l0 = n_load; f0 = n_ferr;
        @(posedge clk); #1;
        rx = 1'b0;
        #50;
        rx = 1'b1;
        wait_cycles(40);
        check("t3_glitch_no_load", 32'(n_load - l0), 32'd0);
        check("t3_glitch_no_ferr", 32'(n_ferr - f0), 32'd0);
        check("t3_idle_after", 32'(dbg_state), 32'(ST_IDLE));
        send_frame(8'h81, 1'b1, BIT_NOM);
        wait_cycles(20);
        check("t3_loads", 32'(n_load - l0), 32'd1);
        check("t3_data", 32'(last_data), 32'h81);

        // 0x3C with a low stop bit, then 0xC3 left pending in the holding reg.
        l0 = n_load; f0 = n_ferr;
        send_frame(8'h3C, 1'b0, BIT_NOM);
        wait_cycles(30);
        check("t4_ferr", 32'(n_ferr - f0), 32'd1);
        check("t4_no_load", 32'(n_load - l0), 32'd0);
        check("t4_valid_low", 32'(rx_valid), 32'd0);
        ready_force = 1'b0;
        send_frame(8'hC3, 1'b1, BIT_NOM);
        wait_cycles(20);
        check("t4_loads", 32'(n_load - l0), 32'd1);
        check("t4_data", 32'(rx_data), 32'hC3);
        check("t4_valid", 32'(rx_valid), 32'd1);
        check_drained("t4");

        // Reset during data bit 4 of 0xFF.
        @(posedge clk); #1;
        rx = 1'b0;
        #(BIT_NOM);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b1;
            #(BIT_NOM);
        end
        #(BIT_NOM / 2.0);
        reset = 1'b1;
        #1;
        check("t5_rst_data", 32'(rx_data), 32'h00);
        check("t5_rst_valid", 32'(rx_valid), 32'd0);
        check("t5_rst_ferr", 32'(frame_err), 32'd0);
        check("t5_rst_ovr", 32'(overrun), 32'd0);
        check("t5_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        wait_cycles(5);
        ready_force = 1'b1;
        reset = 1'b0;
        l0 = n_load; o0 = n_ovr; f0 = n_ferr;
        wait_cycles(200);
        check("t5_abandoned", 32'((n_load - l0) + (n_ovr - o0) + (n_ferr - f0)), 32'd0);
        send_frame(8'h12, 1'b1, BIT_NOM);
        wait_cycles(20);
        check("t5_loads", 32'(n_load - l0), 32'd1);
        check("t5_data", 32'(last_data), 32'h12);

        // 256 random bytes, alternating +/-1.5 % baud, random consumer.
        l0 = n_load; o0 = n_ovr;
        ready_mode = 1'b1;
        for (int i = 0; i < 256; i++) begin
            b = 8'($urandom_range(0, 255));
            send_frame(b, 1'b1, (i % 2 == 0) ? BIT_SLOW : BIT_FAST);
            if ($urandom_range(0, 3) == 0) #($urandom_range(1, 40));
        end
        ready_mode = 1'b0;
        ready_force = 1'b1;
        wait_cycles(400);
        check("t6_all_accounted", 32'((n_load - l0) + (n_ovr - o0)), 32'd256);
        check("t6_valid_drained", 32'(rx_valid), 32'd0);
        check_drained("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #5ms;
        n_err++;
        $display("FAIL timeout: simulation time limit reached, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
